// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller and the forwarding unit.
//  hz_state_e : sequencer state encoding (RUN=0, MD_BUSY=1)
//  REG_X0     : architectural zero register index
package hazard_controller_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//  clk : clock
//  rst : asynchronous active-high reset, clears the count
//  inc : count one event this cycle
//  cnt : current count, holds at all-ones
module hazard_controller_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage core. Resolves load-use hazards, taken branches and
// multi-cycle MUL/DIV ops that forwarding cannot cover, and keeps stall/flush counters.
//  RS1_D/RS2_D/RD_E/ResultSrcE0 : load-use detect inputs
//  PCSrcE                       : taken branch/jump resolved in Execute
//  MdOpE/MdDone/MdStart         : MUL/DIV unit handshake
//  StallF/D/E, FlushD/E/M       : per-stage stall and flush controls (combinational)
//  MdError                      : sticky MUL/DIV timeout flag
//  StallCnt/FlushCnt            : saturating performance counters
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MdOpE,
  input  logic             MdDone,
  output logic             MdStart,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdError,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned TmoW = $clog2(MD_TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MD_TIMEOUT - 1);

  hz_state_e       state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            md_ack_q, md_ack_d;
  logic            md_err_q, md_err_d;

  logic load_use;
  logic md_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

  assign load_use = ResultSrcE0 && (RD_E != REG_X0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    md_ack_d = md_ack_q;
    md_err_d = md_err_q;
    md_start = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;

    unique case (state_q)
      RUN: begin
        // md_ack blocks a restart by the same MUL/DIV still sitting in EX after completion.
        if (MdOpE && !md_ack_q) begin
          md_start = 1'b1;
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          tmo_d    = '0;
          state_d  = MD_BUSY;
        end else if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MD_BUSY: begin
        if (MdDone) begin
          // Release: EX/MEM captures the result this cycle.
          md_ack_d = 1'b1;
          state_d  = RUN;
        end else if (tmo_q == TmoLast) begin
          // Abort: no valid result, so keep the bubble going into MEM.
          flush_m  = 1'b1;
          md_err_d = 1'b1;
          md_ack_d = 1'b1;
          state_d  = RUN;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          tmo_d   = tmo_q + TmoW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if ((state_q == RUN) && md_ack_q && !stall_e) begin
      md_ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      tmo_q    <= '0;
      md_ack_q <= 1'b0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      md_ack_q <= md_ack_d;
      md_err_q <= md_err_d;
    end
  end

  // Controls are forced low while reset is held, independent of state.
  assign MdStart = md_start & ~rst;
  assign StallF  = stall_f & ~rst;
  assign StallD  = stall_d & ~rst;
  assign StallE  = stall_e & ~rst;
  assign FlushD  = flush_d & ~rst;
  assign FlushE  = flush_e & ~rst;
  assign FlushM  = flush_m & ~rst;
  assign MdError = md_err_q;

  hazard_controller_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(StallF),
    .cnt(StallCnt)
  );

  hazard_controller_sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(FlushD | FlushE),
    .cnt(FlushCnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the stimulus process runs a behavioural model and queues
// the expected per-cycle response; a monitor at the falling edge pops and compares.
module tb_hazard_controller;

  localparam int MD_TO  = 8;
  localparam int CW     = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    RS1_D = '0, RS2_D = '0, RD_E = '0;
  logic          ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MdOpE = 1'b0, MdDone = 1'b0;
  logic          MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdError;
  logic [CW-1:0] StallCnt, FlushCnt;

  hazard_controller #(
    .MD_TIMEOUT(MD_TO),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RS1_D      (RS1_D),
    .RS2_D      (RS2_D),
    .RD_E       (RD_E),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE     (PCSrcE),
    .MdOpE      (MdOpE),
    .MdDone     (MdDone),
    .MdStart    (MdStart),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .MdError    (MdError),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  always #5 clk = ~clk;

  // ctl = {MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM}
  typedef struct packed {
    logic [6:0]    ctl;
    logic          fm_care;
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit m_busy    = 1'b0;
  int m_stalled = 0;   // stall cycles spent on the current MUL/DIV op, including the start cycle
  bit m_ack     = 1'b0;
  bit m_err     = 1'b0;
  int m_sc      = 0;
  int m_fc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model(input bit r, input logic [4:0] rs1, rs2, rd,
                       input bit ld, pc, mdop, done);
    exp_t e;
    bit st = 0, sf = 0, sd = 0, se = 0, fd = 0, fe = 0, fm = 0, care = 1;
    if (r) begin
      m_busy = 0; m_stalled = 0; m_ack = 0; m_err = 0; m_sc = 0; m_fc = 0;
      e.err = 1'b0; e.sc = '0; e.fc = '0;
    end else begin
      e.err = m_err; e.sc = CW'(m_sc); e.fc = CW'(m_fc);
      if (!m_busy) begin
        if (mdop && !m_ack) begin
          st = 1; sf = 1; sd = 1; se = 1; fm = 1;
          m_busy = 1; m_stalled = 1;
        end else if (pc) begin
          fd = 1; fe = 1;
        end else if (ld && rd != 0 && (rd == rs1 || rd == rs2)) begin
          sf = 1; sd = 1; fe = 1;
        end
        m_ack = 0;
      end else if (done) begin
        m_busy = 0; m_ack = 1;
      end else if (m_stalled == MD_TO) begin
        care = 0;
        m_err = 1; m_busy = 0; m_ack = 1;
      end else begin
        sf = 1; sd = 1; se = 1; fm = 1;
        m_stalled++;
      end
      m_sc = (m_sc + int'(sf) > CntMax) ? CntMax : m_sc + int'(sf);
      m_fc = (m_fc + int'(fd | fe) > CntMax) ? CntMax : m_fc + int'(fd | fe);
    end
    e.ctl     = {st, sf, sd, se, fd, fe, fm};
    e.fm_care = care;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [4:0] rs1, rs2, rd,
                      input bit ld, pc, mdop, done);
    @(posedge clk);
    #1;
    rst = r; RS1_D = rs1; RS2_D = rs2; RD_E = rd;
    ResultSrcE0 = ld; PCSrcE = pc; MdOpE = mdop; MdDone = done;
    model(r, rs1, rs2, rd, ld, pc, mdop, done);
  endtask

  task automatic idle();
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // Reset asserted part-way through a cycle, away from any clock edge.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model(1, RS1_D, RS2_D, RD_E, ResultSrcE0, PCSrcE, MdOpE, MdDone);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act, mask;
    if (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      mask = {6'h3f, e.fm_care};
      act  = {MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM};
      check("ctl", int'(act & mask), int'(e.ctl & mask));
      check("MdError", int'(MdError), int'(e.err));
      check("StallCnt", int'(StallCnt), int'(e.sc));
      check("FlushCnt", int'(FlushCnt), int'(e.fc));
    end
  end

  initial begin
    step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle();

    // Load-use, then x0 destination which must not stall
    step(0, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0);
    idle();
    step(0, 5'd0, 5'd2, 5'd0, 1, 0, 0, 0);
    step(0, 5'd3, 5'd6, 5'd6, 1, 0, 0, 0);
    idle();

    // Branch beats load-use
    step(0, 5'd7, 5'd1, 5'd7, 1, 1, 0, 0);
    idle();

    // MUL/DIV with MdDone four cycles after start, op still in EX one cycle after release
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle();
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);

    // MdOpE with PCSrcE: MdOpE wins
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    idle();

    // Timeout
    for (int i = 0; i < 10; i++) step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle();
    idle();

    // Async reset mid-busy, then a stray MdDone in RUN
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    reset_mid();
    step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    idle();

    // Counter saturation
    for (int i = 0; i < 20; i++) step(0, 5'd9, 5'd2, 5'd9, 1, 0, 0, 0);
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           ($urandom_range(1) == 1), ($urandom_range(6) == 0),
           ($urandom_range(9) == 0), ($urandom_range(4) == 0));
      if ($urandom_range(19) == 0) reset_mid();
    end
    idle();

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() > 0) begin
      check("scoreboard_drain", sb_q.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
